layer_profiler: RTL and testbench

Per-layer cycle profiler for the CNN accelerator, sitting directly downstream of the free-running 32-bit cycle counter. It samples the counter's `ticks` bus on layer start/done strobes from the layer sequencer, computes elapsed cycles per layer, and queues `{layer_id, cycles}` records in a small FIFO. The host/testbench drains that FIFO over a valid/ready interface. Cycles during which the counter is stopped are excluded automatically, because the profiler only differences counter samples.

---
 rtl/layer_prof_pkg.sv | 17 +
 rtl/layer_prof_fifo.sv | 59 +++++
 rtl/layer_profiler.sv | 150 +++++++++++++++
 tb/tb_layer_profiler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/layer_prof_pkg.sv
// Shared types and default widths for the per-layer cycle profiler.
package layer_prof_pkg;

  localparam int TICK_W_D = 32;
  localparam int ID_W_D   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } prof_state_t;

  typedef struct packed {
    logic [ID_W_D-1:0]   id;
    logic [TICK_W_D-1:0] cycles;
  } prof_rec_t;

endpackage

// File: rtl/layer_prof_fifo.sv
// Record FIFO for the layer profiler: DEPTH entries, pointers carry one extra
// wrap bit so full and empty are distinguishable. Head data reads as zero when empty.
module layer_prof_fifo
  import layer_prof_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = prof_rec_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  rec_t                     i_data,
  input  logic                     i_pop,
  output rec_t                     o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  rec_t        r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/layer_profiler.sv
// Per-layer cycle profiler: differences counter samples between start/done strobes
// and queues {id, cycles} records. Define LAYER_PROF_MAX_EN to build the max_cycles register.
module layer_profiler
  import layer_prof_pkg::*;
#(
  parameter int TICK_W = TICK_W_D,
  parameter int ID_W   = ID_W_D,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TICK_W-1:0]        ticks,
  input  logic                     layer_start,
  input  logic [ID_W-1:0]          layer_id,
  input  logic                     layer_done,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [ID_W-1:0]          rec_id,
  output logic [TICK_W-1:0]        rec_cycles,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     abort,
  input  logic                     clr_flags,
  output logic [TICK_W-1:0]        max_cycles
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [TICK_W-1:0] cycles;
  } rec_t;

  prof_state_t r_state;
  prof_state_t w_state_next;

  logic [TICK_W-1:0] r_start_tick;
  logic [ID_W-1:0]   r_cur_id;
  logic              r_overflow;
  logic              r_abort;

  logic              w_push;
  logic              w_latch;
  logic              w_abort_set;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [TICK_W-1:0] w_elapsed;
  rec_t              w_rec_in;
  rec_t              w_rec_out;

  // Modular subtraction makes counter wrap-around come out right for free.
  assign w_elapsed = ticks - r_start_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_latch      = 1'b0;
    w_abort_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (layer_start) begin
          w_latch      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (layer_done) w_push = 1'b1;
        if (layer_start) begin
          w_latch     = 1'b1;
          w_abort_set = !layer_done;
        end else if (layer_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_tick <= '0;
      r_cur_id     <= '0;
    end else if (w_latch) begin
      r_start_tick <= ticks;
      r_cur_id     <= layer_id;
    end
  end

  assign w_pop = !w_empty && rec_ready;

  // Setting events win over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (clr_flags)             r_overflow <= 1'b0;
      if (w_abort_set)                r_abort    <= 1'b1;
      else if (clr_flags)             r_abort    <= 1'b0;
    end
  end

  assign w_rec_in.id     = r_cur_id;
  assign w_rec_in.cycles = w_elapsed;

  layer_prof_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_rec_in),
    .i_pop   (w_pop),
    .o_data  (w_rec_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

`ifdef LAYER_PROF_MAX_EN
  logic [TICK_W-1:0] r_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max <= '0;
    end else if (w_push && (w_elapsed > r_max)) begin
      r_max <= w_elapsed;
    end
  end

  assign max_cycles = r_max;
`else
  assign max_cycles = '0;
`endif

  assign rec_valid  = !w_empty;
  assign rec_id     = w_rec_out.id;
  assign rec_cycles = w_rec_out.cycles;
  assign busy       = (r_state == RUN);
  assign overflow   = r_overflow;
  assign abort      = r_abort;

endmodule

// File: tb/tb_layer_profiler.sv
// Directed self-checking bench for layer_profiler; inputs change and outputs are
// sampled on the falling clock edge.
module tb_layer_profiler;

  localparam int TICK_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [TICK_W-1:0]      ticks;
  logic                   layer_start;
  logic [ID_W-1:0]        layer_id;
  logic                   layer_done;
  logic                   rec_valid;
  logic                   rec_ready;
  logic [ID_W-1:0]        rec_id;
  logic [TICK_W-1:0]      rec_cycles;
  logic                   busy;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   abort;
  logic                   clr_flags;
  logic [TICK_W-1:0]      max_cycles;

  int n_cmp = 0;
  int n_err = 0;

`ifdef LAYER_PROF_MAX_EN
  localparam logic [TICK_W-1:0] MAX_AFTER_T3 = 32'd50;
  localparam logic [TICK_W-1:0] MAX_AFTER_T6 = 32'd100;
`else
  localparam logic [TICK_W-1:0] MAX_AFTER_T3 = 32'd0;
  localparam logic [TICK_W-1:0] MAX_AFTER_T6 = 32'd0;
`endif

  layer_profiler #(
    .TICK_W (TICK_W),
    .ID_W   (ID_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ticks       (ticks),
    .layer_start (layer_start),
    .layer_id    (layer_id),
    .layer_done  (layer_done),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_id      (rec_id),
    .rec_cycles  (rec_cycles),
    .busy        (busy),
    .count       (count),
    .overflow    (overflow),
    .abort       (abort),
    .clr_flags   (clr_flags),
    .max_cycles  (max_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock of stimulus; rec_ready returns to its prior level afterwards.
  task automatic pulse(input logic s, input logic [ID_W-1:0] id, input logic d,
                       input logic [TICK_W-1:0] t, input logic r, input logic c);
    logic saved;
    saved = rec_ready;
    @(negedge clk);
    ticks       = t;
    layer_start = s;
    layer_id    = id;
    layer_done  = d;
    rec_ready   = r;
    clr_flags   = c;
    @(negedge clk);
    layer_start = 1'b0;
    layer_done  = 1'b0;
    clr_flags   = 1'b0;
    rec_ready   = saved;
  endtask

  // Pop exactly one record (called at a falling edge).
  task automatic pop1();
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ticks = '0; layer_start = 1'b0; layer_id = '0;
    layer_done = 1'b0; rec_ready = 1'b0; clr_flags = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_id", rec_id, 0);
    check("rst_cycles", rec_cycles, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_abort", abort, 0);
    check("rst_max", max_cycles, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic start/done with consumer ready.
    rec_ready = 1'b1;
    pulse(1, 4'd3, 0, 32'd100, 1, 0);
    check("t1_busy", busy, 1);
    pulse(0, 4'd0, 1, 32'd150, 1, 0);
    check("t1_valid", rec_valid, 1);
    check("t1_id", rec_id, 3);
    check("t1_cycles", rec_cycles, 50);
    check("t1_count", count, 1);
    check("t1_busy_low", busy, 0);
    @(negedge clk);
    check("t1_drained", count, 0);
    check("t1_valid_low", rec_valid, 0);
    check("t1_ovf", overflow, 0);
    check("t1_abort", abort, 0);

    // Counter wrap-around.
    pulse(1, 4'd4, 0, 32'hFFFF_FFF0, 1, 0);
    pulse(0, 4'd0, 1, 32'h0000_0010, 1, 0);
    check("t2_cycles", rec_cycles, 32'h20);
    @(negedge clk);
    rec_ready = 1'b0;

    // Fill, full push+pop, overflow, drain.
    for (int i = 0; i < 8; i++) begin
      pulse(1, 4'(i), 0, 32'(2000 + 100 * i), 0, 0);
      pulse(0, 4'd0, 1, 32'(2000 + 100 * i + 10 + i), 0, 0);
    end
    check("t3_count_full", count, 8);
    check("t3_ovf_not_yet", overflow, 0);
    check("t3_head0", rec_id, 0);
    pulse(1, 4'd8, 0, 32'd2800, 0, 0);
    pulse(0, 4'd0, 1, 32'd2818, 1, 0);
    check("t3_pushpop_count", count, 8);
    check("t3_pushpop_ovf", overflow, 0);
    check("t3_head1_id", rec_id, 1);
    pulse(1, 4'd9, 0, 32'd2900, 0, 0);
    pulse(0, 4'd0, 1, 32'd2919, 0, 0);
    check("t3_ovf_count", count, 8);
    check("t3_ovf", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t3_drain%0d_valid", k), rec_valid, 1);
      check($sformatf("t3_drain%0d_id", k), rec_id, k);
      check($sformatf("t3_drain%0d_cycles", k), rec_cycles, 10 + k);
      pop1();
    end
    check("t3_empty", rec_valid, 0);
    check("t3_count0", count, 0);
    check("t3_max", max_cycles, MAX_AFTER_T3);
    pulse(0, 4'd0, 0, 32'd0, 0, 1);
    check("t3_ovf_cleared", overflow, 0);

    // Restart before done.
    pulse(1, 4'd1, 0, 32'd10, 0, 0);
    pulse(1, 4'd2, 0, 32'd20, 0, 0);
    check("t4_abort", abort, 1);
    check("t4_busy", busy, 1);
    pulse(0, 4'd0, 1, 32'd35, 0, 0);
    check("t4_count", count, 1);
    check("t4_id", rec_id, 2);
    check("t4_cycles", rec_cycles, 15);
    pop1();
    check("t4_count0", count, 0);
    pulse(0, 4'd0, 0, 32'd40, 0, 1);
    check("t4_abort_cleared", abort, 0);
    pulse(1, 4'd5, 0, 32'd50, 0, 0);
    pulse(1, 4'd6, 0, 32'd60, 0, 1);
    check("t4_set_beats_clr", abort, 1);
    pulse(0, 4'd0, 0, 32'd61, 0, 1);
    check("t4_abort_clr2", abort, 0);
    pulse(0, 4'd0, 1, 32'd62, 0, 0);
    pop1();

    // Back-to-back done+start.
    pulse(1, 4'd1, 0, 32'd10, 0, 0);
    pulse(1, 4'd2, 1, 32'd40, 0, 0);
    check("t5_busy_mid", busy, 1);
    check("t5_abort", abort, 0);
    check("t5_count1", count, 1);
    check("t5_id1", rec_id, 1);
    check("t5_cyc1", rec_cycles, 30);
    pulse(0, 4'd0, 1, 32'd70, 0, 0);
    check("t5_count2", count, 2);
    check("t5_busy_end", busy, 0);
    pop1();
    check("t5_id2", rec_id, 2);
    check("t5_cyc2", rec_cycles, 30);
    pop1();
    check("t5_empty", rec_valid, 0);

    // Reset mid-layer with queued records.
    pulse(1, 4'd7, 0, 32'd5000, 0, 0);
    pulse(0, 4'd0, 1, 32'd5100, 0, 0);
    pulse(1, 4'd8, 0, 32'd10, 0, 0);
    pulse(0, 4'd0, 1, 32'd17, 0, 0);
    pulse(1, 4'd9, 0, 32'd20, 0, 0);
    pulse(0, 4'd0, 1, 32'd28, 0, 0);
    pulse(1, 4'd10, 0, 32'd30, 0, 0);
    check("t6_count3", count, 3);
    check("t6_busy", busy, 1);
    check("t6_max", max_cycles, MAX_AFTER_T6);
    #2 rst = 1'b1;
    #1;
    check("t6_busy_rst", busy, 0);
    check("t6_valid_rst", rec_valid, 0);
    check("t6_id_rst", rec_id, 0);
    check("t6_cycles_rst", rec_cycles, 0);
    check("t6_count_rst", count, 0);
    check("t6_ovf_rst", overflow, 0);
    check("t6_abort_rst", abort, 0);
    check("t6_max_rst", max_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_count_after", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
